sync32_feed_fifo: RTL and testbench



---
 rtl/sync32_feed_pkg.sv | 21 ++
 rtl/sync32_feed_ram.sv | 25 ++
 rtl/sync32_feed_fifo.sv | 91 +++++++++
 tb/tb_sync32_feed_fifo.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sync32_feed_pkg.sv
// Shared word type and constant helpers for the sync32 feeder FIFO.
// Used by the top (sync32_feed_fifo) and its storage (sync32_feed_ram).
package sync32_feed_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync32_feed_ram.sv
// DEPTH x word_t storage: registered write port, asynchronous read.
// Contents are deliberately not reset; occupancy tracking lives in the top.
module sync32_feed_ram
  import sync32_feed_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              sys_clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge sys_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync32_feed_fifo.sv
// Feeder FIFO for the 32-bit load-enabled sync register; issues the head word on ce & ~hold.
// Min latency 1 cycle, or 0 with SYNC32_FEED_BYPASS_EN; in_ready drops only when full.
module sync32_feed_fifo
  import sync32_feed_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              ce,
  input  logic              hold,
  output logic              ld,
  output logic [WORD_W-1:0] d,
  output logic [AW:0]       level
);

  if (DEPTH < 2 || DEPTH != (1 << AW) || clog2(DEPTH) != AW) begin : g_bad_depth
    $error("sync32_feed_fifo: DEPTH must be a power of two >= 2 and equal 2**AW");
  end

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  word_t         rd_word;
  logic          blocked;
  logic          empty;
  logic          full;
  logic          issue;
  logic          bypass;
  logic          push;

  assign blocked = reset | flush;
  assign empty   = (cnt == '0);
  assign full    = (cnt == LVL_FULL);

`ifdef SYNC32_FEED_BYPASS_EN
  // Cut-through only when nothing is queued, so ordering is preserved.
  assign bypass = empty & in_valid & ce & ~hold & ~blocked;
`else
  assign bypass = 1'b0;
`endif

  // A full FIFO never accepts, even while issuing: the freed slot shows next cycle.
  assign in_ready = ~full & ~blocked;
  assign issue    = ce & ~hold & ~empty & ~blocked;
  assign push     = in_valid & in_ready & ~bypass;
  assign ld       = issue | bypass;
  assign level    = reset ? '0 : cnt;

  always_comb begin
    d = '0;
    if (issue)       d = rd_word;
    else if (bypass) d = in_data;
  end

  always_ff @(posedge sys_clk) begin
    if (blocked) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (issue) rd_ptr <= rd_ptr + AW'(1);
      case ({push, issue})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  sync32_feed_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .sys_clk (sys_clk),
    .we      (push),
    .waddr   (wr_ptr),
    .wdata   (in_data),
    .raddr   (rd_ptr),
    .rdata   (rd_word)
  );

endmodule

// File: tb/tb_sync32_feed_fifo.sv
// Self-checking bench for sync32_feed_fifo: vector table, directed corner sequences, random vs queue model.
module tb_sync32_feed_fifo;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          sys_clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          ce;
  logic          hold;
  logic          ld;
  logic [31:0]   d;
  logic [AW:0]   level;

  int n_checks = 0;
  int n_errors = 0;

  always #5 sys_clk = ~sys_clk;

  sync32_feed_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .ce       (ce),
    .hold     (hold),
    .ld       (ld),
    .d        (d),
    .level    (level)
  );

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] dat;
    logic        c;
    logic        h;
    logic        eld;
    logic [31:0] ed;
    logic        erdy;
    logic [2:0]  elvl;
  } vec_t;

  vec_t        tbl[16];
  logic [31:0] q[$];

  function automatic vec_t mk(input logic fl, iv, input logic [31:0] dat, input logic c, h,
                              input logic eld, input logic [31:0] ed, input logic erdy,
                              input logic [2:0] elvl);
    vec_t v;
    v.fl = fl; v.iv = iv; v.dat = dat; v.c = c; v.h = h;
    v.eld = eld; v.ed = ed; v.erdy = erdy; v.elvl = elvl;
    return v;
  endfunction

  task automatic drive(input logic r, fl, iv, input logic [31:0] dat, input logic c, h);
    reset = r; flush = fl; in_valid = iv; in_data = dat; ce = c; hold = h;
    #3;
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic eld, input logic [31:0] ed,
                         input logic erdy, input logic [2:0] elvl);
    chk({tag, ".ld"}, 32'(ld), 32'(eld));
    chk({tag, ".d"}, d, ed);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(erdy));
    chk({tag, ".level"}, 32'(level), 32'(elvl));
  endtask

  initial begin
    // Test 1: single word waits out ce=0, then issues.
    tbl[0]  = mk(0, 1, 32'hDEAD_BEEF, 0, 0,  0, 32'h0,        1, 0);
    tbl[1]  = mk(0, 0, 32'h0,         0, 0,  0, 32'h0,        1, 1);
    tbl[2]  = mk(0, 0, 32'h0,         0, 0,  0, 32'h0,        1, 1);
    tbl[3]  = mk(0, 0, 32'h0,         1, 0,  1, 32'hDEAD_BEEF, 1, 1);
    tbl[4]  = mk(0, 0, 32'h0,         0, 0,  0, 32'h0,        1, 0);
    // Test 2/3: fill to DEPTH, word 5 held back, issue while full, drain in order.
    tbl[5]  = mk(0, 1, 32'd1, 0, 0,  0, 32'h0, 1, 0);
    tbl[6]  = mk(0, 1, 32'd2, 0, 0,  0, 32'h0, 1, 1);
    tbl[7]  = mk(0, 1, 32'd3, 0, 0,  0, 32'h0, 1, 2);
    tbl[8]  = mk(0, 1, 32'd4, 0, 0,  0, 32'h0, 1, 3);
    tbl[9]  = mk(0, 1, 32'd5, 0, 0,  0, 32'h0, 0, 4);
    tbl[10] = mk(0, 1, 32'd5, 1, 0,  1, 32'd1, 0, 4);
    tbl[11] = mk(0, 1, 32'd5, 1, 0,  1, 32'd2, 1, 3);
    tbl[12] = mk(0, 0, 32'd0, 1, 0,  1, 32'd3, 1, 3);
    tbl[13] = mk(0, 0, 32'd0, 1, 0,  1, 32'd4, 1, 2);
    tbl[14] = mk(0, 0, 32'd0, 1, 0,  1, 32'd5, 1, 1);
    tbl[15] = mk(0, 0, 32'd0, 1, 0,  0, 32'h0, 1, 0);

    drive(1, 0, 1, 32'hFFFF_FFFF, 1, 0);
    tick;
    chk_all("reset_cycle", 0, 32'h0, 0, 0);
    tick;

    for (int i = 0; i < 16; i++) begin
      drive(0, tbl[i].fl, tbl[i].iv, tbl[i].dat, tbl[i].c, tbl[i].h);
      chk_all($sformatf("vec%0d", i), tbl[i].eld, tbl[i].ed, tbl[i].erdy, tbl[i].elvl);
      tick;
    end

    // Test 4: hold blocks issue at level 2.
    drive(0, 0, 1, 32'hAAAA_0001, 0, 0); tick;
    drive(0, 0, 1, 32'hAAAA_0002, 0, 0); tick;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 32'h0, 1, 1);
      chk("hold.ld", 32'(ld), 32'd0);
      chk("hold.level", 32'(level), 32'd2);
      tick;
    end
    drive(0, 0, 0, 32'h0, 1, 0);
    chk_all("hold_rel1", 1, 32'hAAAA_0001, 1, 2); tick;
    drive(0, 0, 0, 32'h0, 1, 0);
    chk_all("hold_rel2", 1, 32'hAAAA_0002, 1, 1); tick;
    drive(0, 0, 0, 32'h0, 0, 0);
    chk("hold_end.level", 32'(level), 32'd0);

    // Test 5a: flush at level 3.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 32'hB000_0000 + 32'(i), 0, 0); tick;
    end
    drive(0, 1, 1, 32'hFFFF_0000, 1, 0);
    chk_all("flush_cycle", 0, 32'h0, 0, 3); tick;
    drive(0, 0, 1, 32'h1234_5678, 0, 0);
    chk_all("post_flush", 0, 32'h0, 1, 0); tick;
    drive(0, 0, 0, 32'h0, 1, 0);
    chk_all("flush_first", 1, 32'h1234_5678, 1, 1); tick;

    // Test 5b: reset at level 3.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 32'hC000_0000 + 32'(i), 0, 0); tick;
    end
    drive(1, 0, 1, 32'hFFFF_0001, 1, 0);
    chk_all("midreset_cycle", 0, 32'h0, 0, 0); tick;
    drive(0, 0, 1, 32'h1234_5678, 0, 0);
    chk_all("post_reset", 0, 32'h0, 1, 0); tick;
    drive(0, 0, 0, 32'h0, 1, 0);
    chk_all("reset_first", 1, 32'h1234_5678, 1, 1); tick;

    // Test 6: push into an empty FIFO with ce=1.
    drive(0, 0, 1, 32'hA5A5_0001, 1, 0);
`ifdef SYNC32_FEED_BYPASS_EN
    chk_all("bypass", 1, 32'hA5A5_0001, 1, 0); tick;
    drive(0, 0, 0, 32'h0, 0, 0);
    chk_all("bypass_after", 0, 32'h0, 1, 0); tick;
`else
    chk_all("nobypass", 0, 32'h0, 1, 0); tick;
    drive(0, 0, 0, 32'h0, 0, 0);
    chk_all("nobypass_wait", 0, 32'h0, 1, 1); tick;
    drive(0, 0, 0, 32'h0, 1, 0);
    chk_all("nobypass_issue", 1, 32'hA5A5_0001, 1, 1); tick;
    drive(0, 0, 0, 32'h0, 0, 0);
    chk_all("nobypass_after", 0, 32'h0, 1, 0); tick;
`endif

    // Random traffic against a queue model of the occupancy/order rules.
    drive(1, 0, 0, 32'h0, 0, 0); tick;
    q.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic r, fl, iv, c, h, byp, iss, rdy, eld;
      logic [31:0] dat, ed;
      logic [2:0] elvl;
      r   = ($urandom % 60) == 0;
      fl  = ($urandom % 40) == 0;
      iv  = ($urandom % 10) < 6;
      dat = $urandom;
      c   = ($urandom % 2) == 1;
      h   = ($urandom % 4) == 0;
      rdy = !r && !fl && (q.size() != DEPTH);
      iss = !r && !fl && c && !h && (q.size() != 0);
`ifdef SYNC32_FEED_BYPASS_EN
      byp = !r && !fl && (q.size() == 0) && iv && c && !h;
`else
      byp = 1'b0;
`endif
      eld  = iss || byp;
      ed   = iss ? q[0] : (byp ? dat : 32'h0);
      elvl = r ? 3'd0 : 3'(q.size());
      drive(r, fl, iv, dat, c, h);
      chk_all("rand", eld, ed, rdy, elvl);
      if (r || fl) begin
        q.delete();
      end else begin
        if (iss) void'(q.pop_front());
        if (iv && rdy && !byp) q.push_back(dat);
      end
      tick;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
